// File: rtl/multicycle_control_fsm_if.sv
// Control/memory bundle between the multicycle controller (master) and the datapath + memory (slave).
interface multicycle_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       OP_i;
  logic             Branch_Taken_i;
  logic             Mem_Ready_i;
  logic             Mem_Req_o;
  logic             Mem_We_o;
  logic             IorD_o;
  logic             IR_Write_o;
  logic             PC_Write_o;
  logic [1:0]       PC_Src_o;
  logic [1:0]       ALU_Src_A_o;
  logic [1:0]       ALU_Src_B_o;
  logic [2:0]       ALU_Op_o;
  logic             Reg_Write_o;
  logic [1:0]       Mem_to_Reg_o;
  logic             Retired_o;
  logic [CNT_W-1:0] Retire_Count_o;
  logic             Timeout_o;
  logic             Illegal_o;

  modport master (
    input  OP_i, Branch_Taken_i, Mem_Ready_i,
    output Mem_Req_o, Mem_We_o, IorD_o, IR_Write_o, PC_Write_o, PC_Src_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Reg_Write_o, Mem_to_Reg_o,
           Retired_o, Retire_Count_o, Timeout_o, Illegal_o
  );

  modport slave (
    output OP_i, Branch_Taken_i, Mem_Ready_i,
    input  Mem_Req_o, Mem_We_o, IorD_o, IR_Write_o, PC_Write_o, PC_Src_o,
           ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Reg_Write_o, Mem_to_Reg_o,
           Retired_o, Retire_Count_o, Timeout_o, Illegal_o
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RISC-V sequencer: one shared memory port (req/ready, optional timeout), retire counter.
// Define ILLEGAL_TRAP_EN to park undecoded opcodes in a sticky TRAP state instead of treating them as NOPs.
module multicycle_control_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.master  bus
);
  localparam int              TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TO_EN     = (MEM_TIMEOUT > 0);
  localparam logic [TW-1:0]   WAIT_LAST = (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LW    = 7'h03;
  localparam logic [6:0] OP_SW    = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LUI, EXEC_AUIPC, MEM_ADDR,
    MEM_RD, MEM_WR, MEM_WB, ALU_WB, BRANCH, JAL, JALR
`ifdef ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             timeout_q, timeout_d;
  logic             illegal_q, illegal_d;

  logic       req, we, iord, ir_write, pc_write, reg_write, retired, expired;
  logic [1:0] pc_src, src_a, src_b, m2r;
  logic [2:0] alu_op;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    illegal_d  = illegal_q;
    req = 1'b0; we = 1'b0; iord = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
    reg_write = 1'b0; retired = 1'b0;
    pc_src = 2'b00; src_a = 2'b00; src_b = 2'b00; m2r = 2'b00; alu_op = 3'b000;
    // The last permitted wait cycle; a Ready arriving in it still completes normally.
    expired = TO_EN && (wait_cnt_q == WAIT_LAST);

    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (bus.Mem_Ready_i) begin
          ir_write = 1'b1; pc_write = 1'b1; src_b = 2'b01; alu_op = 3'b011;
          state_d  = DECODE;
        end else if (expired) begin
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      DECODE: begin
        src_a = 2'b10; src_b = 2'b10; alu_op = 3'b011;
        case (bus.OP_i)
          OP_R:          state_d = EXEC_R;
          OP_I:          state_d = EXEC_I;
          OP_LUI:        state_d = EXEC_LUI;
          OP_AUIPC:      state_d = EXEC_AUIPC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_B:          state_d = BRANCH;
          OP_JAL:        state_d = JAL;
          OP_JALR:       state_d = JALR;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = TRAP;
            illegal_d = 1'b1;
`else
            state_d   = FETCH;
`endif
          end
        endcase
      end
      EXEC_R:     begin src_a = 2'b01; alu_op = 3'b000; state_d = ALU_WB; end
      EXEC_I:     begin src_a = 2'b01; src_b = 2'b10; alu_op = 3'b001; state_d = ALU_WB; end
      EXEC_LUI:   begin src_b = 2'b10; alu_op = 3'b010; state_d = ALU_WB; end
      EXEC_AUIPC: begin src_a = 2'b10; src_b = 2'b10; alu_op = 3'b111; state_d = ALU_WB; end
      MEM_ADDR: begin
        src_a = 2'b01; src_b = 2'b10; alu_op = 3'b011;
        state_d = (bus.OP_i == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD, MEM_WR: begin
        req  = 1'b1;
        we   = (state_q == MEM_WR);
        iord = 1'b1;
        if (bus.Mem_Ready_i) begin
          state_d = (state_q == MEM_RD) ? MEM_WB : FETCH;
          retired = (state_q == MEM_WR);
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = FETCH;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      MEM_WB: begin reg_write = 1'b1; m2r = 2'b01; retired = 1'b1; state_d = FETCH; end
      ALU_WB: begin reg_write = 1'b1; m2r = 2'b00; retired = 1'b1; state_d = FETCH; end
      BRANCH: begin
        src_a = 2'b01; alu_op = 3'b100; pc_src = 2'b01;
        pc_write = bus.Branch_Taken_i; retired = 1'b1; state_d = FETCH;
      end
      JAL: begin
        reg_write = 1'b1; m2r = 2'b10; pc_write = 1'b1; pc_src = 2'b01;
        retired = 1'b1; state_d = FETCH;
      end
      JALR: begin
        src_a = 2'b01; src_b = 2'b10; alu_op = 3'b110; reg_write = 1'b1; m2r = 2'b10;
        pc_write = 1'b1; pc_src = 2'b10; retired = 1'b1; state_d = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = FETCH;
    endcase

    // Reset kills the in-flight instruction: nothing may be written in the reset cycle.
    if (reset) begin
      req = 1'b0; we = 1'b0; iord = 1'b0; ir_write = 1'b0; pc_write = 1'b0;
      reg_write = 1'b0; retired = 1'b0;
      pc_src = 2'b00; src_a = 2'b00; src_b = 2'b00; m2r = 2'b00; alu_op = 3'b000;
    end

    count_d = retired ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      count_q    <= '0;
      timeout_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.Mem_Req_o      = req;
  assign bus.Mem_We_o       = we;
  assign bus.IorD_o         = iord;
  assign bus.IR_Write_o     = ir_write;
  assign bus.PC_Write_o     = pc_write;
  assign bus.PC_Src_o       = pc_src;
  assign bus.ALU_Src_A_o    = src_a;
  assign bus.ALU_Src_B_o    = src_b;
  assign bus.ALU_Op_o       = alu_op;
  assign bus.Reg_Write_o    = reg_write;
  assign bus.Mem_to_Reg_o   = m2r;
  assign bus.Retired_o      = retired;
  assign bus.Retire_Count_o = count_q;
  assign bus.Timeout_o      = timeout_q;
  assign bus.Illegal_o      = illegal_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (CNT_W=4 to reach wrap, MEM_TIMEOUT=4).
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.CNT_W(4)) bif ();
  multicycle_control_fsm #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // {Req,We,IorD,IR_Write,PC_Write,PC_Src,A,B,Op,Reg_Write,Mem_to_Reg,Retired}
  logic [17:0] obs;
  assign obs = {bif.Mem_Req_o, bif.Mem_We_o, bif.IorD_o, bif.IR_Write_o, bif.PC_Write_o,
                bif.PC_Src_o, bif.ALU_Src_A_o, bif.ALU_Src_B_o, bif.ALU_Op_o,
                bif.Reg_Write_o, bif.Mem_to_Reg_o, bif.Retired_o};

  localparam logic [17:0] E_IDLE      = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_FETCH_W   = {5'b10000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_FETCH_R   = {5'b10011, 2'b00, 2'b00, 2'b01, 3'b011, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_DECODE    = {5'b00000, 2'b00, 2'b10, 2'b10, 3'b011, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_EXEC_R    = {5'b00000, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_EXEC_I    = {5'b00000, 2'b00, 2'b01, 2'b10, 3'b001, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_EXEC_LUI  = {5'b00000, 2'b00, 2'b00, 2'b10, 3'b010, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_EXEC_AUI  = {5'b00000, 2'b00, 2'b10, 2'b10, 3'b111, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_ADDR  = {5'b00000, 2'b00, 2'b01, 2'b10, 3'b011, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_RD    = {5'b10100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_WR    = {5'b11100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b0};
  localparam logic [17:0] E_MEM_WR_R  = {5'b11100, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 2'b00, 1'b1};
  localparam logic [17:0] E_MEM_WB    = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 2'b01, 1'b1};
  localparam logic [17:0] E_ALU_WB    = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 2'b00, 1'b1};
  localparam logic [17:0] E_BR_NT     = {5'b00000, 2'b01, 2'b01, 2'b00, 3'b100, 1'b0, 2'b00, 1'b1};
  localparam logic [17:0] E_BR_T      = {5'b00001, 2'b01, 2'b01, 2'b00, 3'b100, 1'b0, 2'b00, 1'b1};
  localparam logic [17:0] E_JAL       = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1, 2'b10, 1'b1};
  localparam logic [17:0] E_JALR      = {5'b00001, 2'b10, 2'b01, 2'b10, 3'b110, 1'b1, 2'b10, 1'b1};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Check the current cycle's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [17:0] e);
    #1;
    chk(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int e);
    chk(tag, 32'(bif.Retire_Count_o), 32'(e));
  endtask

  task automatic jal_instr();
    bif.OP_i = 7'h6F; bif.Mem_Ready_i = 1'b1;
    cyc("jal_fetch", E_FETCH_R);
    cyc("jal_decode", E_DECODE);
    cyc("jal_exec", E_JAL);
  endtask

  initial begin
    reset = 1'b1;
    bif.OP_i = 7'h33; bif.Branch_Taken_i = 1'b0; bif.Mem_Ready_i = 1'b1;
    @(posedge clk); #1;
    cyc("reset_strobes", E_IDLE);
    chk_cnt("reset_count", 0);
    chk("reset_timeout", 32'(bif.Timeout_o), 32'd0);
    chk("reset_illegal", 32'(bif.Illegal_o), 32'd0);

    reset = 1'b0;
    cyc("r_fetch", E_FETCH_R);
    cyc("r_decode", E_DECODE);
    cyc("r_exec", E_EXEC_R);
    cyc("r_wb", E_ALU_WB);
    chk_cnt("r_count", 1);

    bif.OP_i = 7'h03;
    cyc("lw_fetch", E_FETCH_R);
    cyc("lw_decode", E_DECODE);
    bif.Mem_Ready_i = 1'b0;
    cyc("lw_addr", E_MEM_ADDR);
    for (int i = 0; i < 3; i++) cyc("lw_wait", E_MEM_RD);
    bif.Mem_Ready_i = 1'b1;
    cyc("lw_rdy", E_MEM_RD);
    cyc("lw_wb", E_MEM_WB);
    chk_cnt("lw_count", 2);

    bif.OP_i = 7'h63; bif.Branch_Taken_i = 1'b0;
    cyc("bnt_fetch", E_FETCH_R);
    cyc("bnt_decode", E_DECODE);
    cyc("bnt_exec", E_BR_NT);
    bif.Branch_Taken_i = 1'b1;
    cyc("bt_fetch", E_FETCH_R);
    cyc("bt_decode", E_DECODE);
    cyc("bt_exec", E_BR_T);
    chk_cnt("br_count", 4);

    bif.OP_i = 7'h13;
    cyc("i_fetch", E_FETCH_R); cyc("i_decode", E_DECODE);
    cyc("i_exec", E_EXEC_I);   cyc("i_wb", E_ALU_WB);
    bif.OP_i = 7'h37;
    cyc("lui_fetch", E_FETCH_R); cyc("lui_decode", E_DECODE);
    cyc("lui_exec", E_EXEC_LUI); cyc("lui_wb", E_ALU_WB);
    bif.OP_i = 7'h17;
    cyc("aui_fetch", E_FETCH_R); cyc("aui_decode", E_DECODE);
    cyc("aui_exec", E_EXEC_AUI); cyc("aui_wb", E_ALU_WB);
    jal_instr();
    bif.OP_i = 7'h67;
    cyc("jalr_fetch", E_FETCH_R); cyc("jalr_decode", E_DECODE);
    cyc("jalr_exec", E_JALR);
    chk_cnt("alu_jump_count", 9);

    bif.OP_i = 7'h23;
    cyc("sw_fetch", E_FETCH_R); cyc("sw_decode", E_DECODE);
    cyc("sw_addr", E_MEM_ADDR); cyc("sw_wr", E_MEM_WR_R);
    chk_cnt("sw_count", 10);
    chk("pre_timeout", 32'(bif.Timeout_o), 32'd0);

    // Ready never arrives: four wait cycles, then abort to FETCH without retiring.
    bif.OP_i = 7'h03;
    cyc("to_fetch", E_FETCH_R); cyc("to_decode", E_DECODE);
    bif.Mem_Ready_i = 1'b0;
    cyc("to_addr", E_MEM_ADDR);
    for (int i = 0; i < 4; i++) cyc("to_wait", E_MEM_RD);
    chk("to_flag", 32'(bif.Timeout_o), 32'd1);
    chk_cnt("to_count", 10);
    cyc("to_refetch", E_FETCH_W);

    // Ready on the final permitted wait cycle completes the store.
    bif.OP_i = 7'h23; bif.Mem_Ready_i = 1'b1;
    cyc("lim_fetch", E_FETCH_R); cyc("lim_decode", E_DECODE);
    bif.Mem_Ready_i = 1'b0;
    cyc("lim_addr", E_MEM_ADDR);
    for (int i = 0; i < 3; i++) cyc("lim_wait", E_MEM_WR);
    bif.Mem_Ready_i = 1'b1;
    cyc("lim_rdy", E_MEM_WR_R);
    chk_cnt("lim_count", 11);
    chk("lim_timeout_sticky", 32'(bif.Timeout_o), 32'd1);

    // Reset arriving while a store waits must suppress the write.
    cyc("rst_fetch", E_FETCH_R); cyc("rst_decode", E_DECODE);
    bif.Mem_Ready_i = 1'b0;
    cyc("rst_addr", E_MEM_ADDR);
    cyc("rst_wr", E_MEM_WR);
    reset = 1'b1; bif.Mem_Ready_i = 1'b1;
    cyc("rst_abort", E_IDLE);
    reset = 1'b0; bif.Mem_Ready_i = 1'b0;
    cyc("rst_refetch", E_FETCH_W);
    chk_cnt("rst_count", 0);
    chk("rst_timeout", 32'(bif.Timeout_o), 32'd0);

    for (int i = 0; i < 15; i++) jal_instr();
    chk_cnt("cnt_max", 15);
    jal_instr();
    chk_cnt("cnt_wrap", 0);
    jal_instr();
    chk_cnt("cnt_after_wrap", 1);

    bif.OP_i = 7'h7F; bif.Mem_Ready_i = 1'b1;
    cyc("ill_fetch", E_FETCH_R);
    cyc("ill_decode", E_DECODE);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_flag", 32'(bif.Illegal_o), 32'd1);
    cyc("ill_trap0", E_IDLE);
    cyc("ill_trap1", E_IDLE);
    chk("ill_flag_hold", 32'(bif.Illegal_o), 32'd1);
`else
    chk("ill_flag", 32'(bif.Illegal_o), 32'd0);
    cyc("ill_nop_fetch", E_FETCH_R);
`endif
    chk_cnt("ill_count", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
